// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: operand request side and result side.
// The master drives operands and accepts results; the slave is the converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      A;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   B;
  logic                  M3;
  logic                  Z;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, B, M3, Z
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, B, M3, Z
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock,
// with serially computed divisible-by-3 and zero flags.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);

  // True when DIGITS decimal digits can hold every WIDTH-bit value.
  function automatic bit digits_ok(input int w, input int d);
    longint unsigned lim;
    longint unsigned p;
    lim = (64'd1 << w) - 64'd1;
    p   = 64'd1;
    for (int k = 0; k < d; k++) begin
      p = p * 64'd10;
      if (p > lim) return 1'b1;
    end
    return 1'b0;
  endfunction

  if (WIDTH < 2 || WIDTH > 62 || !digits_ok(WIDTH, DIGITS)) begin : g_param_err
    $error("bin2bcd_seq: DIGITS=%0d cannot represent WIDTH=%0d (or WIDTH out of range)",
           DIGITS, WIDTH);
  end

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   acc;
  logic [1:0]            r;
  logic                  zf;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   bres;
  logic                  m3res;
  logic                  zres;

  logic                  bitin;
  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_next;
  logic [WIDTH-1:0]      bin_next;
  logic [1:0]            r_next;
  logic                  zf_next;

  // One double-dabble step: correct digits >= 5, then shift in the next MSB.
  // Remainder mod 3 tracks the value of the bits consumed so far.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    bitin    = bin[WIDTH-1];
    acc_next = (acc_adj << 1) | {{(4*DIGITS-1){1'b0}}, bitin};
    bin_next = bin << 1;
    case (r)
      2'd0:    r_next = bitin ? 2'd1 : 2'd0;
      2'd1:    r_next = bitin ? 2'd0 : 2'd2;
      2'd2:    r_next = bitin ? 2'd2 : 2'd1;
      default: r_next = 2'd0;
    endcase
    zf_next = zf & ~bitin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      acc   <= '0;
      r     <= 2'd0;
      zf    <= 1'b0;
      cnt   <= '0;
      bres  <= '0;
      m3res <= 1'b0;
      zres  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin   <= bus.A;
            acc   <= '0;
            r     <= 2'd0;
            zf    <= 1'b1;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          bin <= bin_next;
          r   <= r_next;
          zf  <= zf_next;
          cnt <= cnt - 1'b1;
          // Last bit consumed: publish the result and hold it until acknowledged.
          if (cnt == CW'(1)) begin
            bres  <= acc_next;
            m3res <= (r_next == 2'd0);
            zres  <= zf_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.B         = bres;
  assign bus.M3        = m3res;
  assign bus.Z         = zres;

endmodule
